// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main control unit: state register, opcode decode,
// per-state datapath strobes, memory-ready waits, illegal-op trap and a
// retired-instruction counter.
//
// state    | code | meaning
// ---------+------+--------------------------------------------------
// FETCH    |  0   | read instruction, PC+4; wait for mem_ready
// DECODE   |  1   | branch target into ALUOut; route by opcode
// R_EXEC   |  2   | R-type ALU op selected by funct
// R_WB     |  3   | write ALUOut to rd
// BEQ      |  4   | compare; load PC from ALUOut if zero
// MEM_ADDR |  5   | base + sign-extended offset
// MEM_WR   |  6   | store; wait for mem_ready
// MEM_RD   |  7   | load; wait for mem_ready
// LW_WB    |  8   | write MDR to rt
// JUMP     |  9   | load PC with jump target
// I_EXEC   | 10   | ADDI / ORI ALU op
// I_WB     | 11   | write ALUOut to rt
// BNE      | 12   | compare; load PC from ALUOut if not zero
// TRAP     | 13   | illegal opcode/funct; sticky until rst
module mc_control_fsm #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  // ALU operation codes (MIPS ALU-control style encoding)
  localparam logic [ALUOP_W-1:0] ALUOP_AND = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = ALUOP_W'(4'b0111);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_BEQ      = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_WR   = 4'd6,
    S_MEM_RD   = 4'd7,
    S_LW_WB    = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_BNE      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= op;
      if (state_q == S_FETCH && mem_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and per-state strobes; everything defaults low
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    pc_source  = 2'd0;
    alu_src_b  = 3'd0;
    alu_op     = '0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        alu_src_b = 3'd1;
        alu_op    = ALUOP_ADD;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 3'd3;
        alu_op    = ALUOP_ADD;
        case (op)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BEQ;
          OP_BNE:        state_d = S_BNE;
          OP_J:          state_d = S_JUMP;
          OP_ADDI,
          OP_ORI:        state_d = S_I_EXEC;
          default:       state_d = S_TRAP;
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
        case (funct)
          6'h20:   alu_op = ALUOP_ADD;
          6'h22:   alu_op = ALUOP_SUB;
          6'h24:   alu_op = ALUOP_AND;
          6'h25:   alu_op = ALUOP_OR;
          6'h2A:   alu_op = ALUOP_SLT;
          default: state_d = S_TRAP;
        endcase
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'd2;
        alu_op    = ALUOP_ADD;
        state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_LW_WB;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = 2'd1;
        pc_en     = (state_q == S_BEQ) ? zero : ~zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_en     = 1'b1;
        pc_source = 2'd2;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        if (op_q == OP_ORI) begin
          alu_src_b = 3'd4;
          alu_op    = ALUOP_OR;
        end else begin
          alu_src_b = 3'd2;
          alu_op    = ALUOP_ADD;
        end
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
    // Reset blanks every strobe so nothing fires during the reset cycle
    if (rst) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      pc_source  = 2'd0;
      alu_src_b  = 3'd0;
      alu_op     = '0;
      illegal_op = 1'b0;
    end
  end

  assign state       = rst ? 4'd0 : state_q;
  assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver expands each instruction
// into its expected per-cycle control word and queues it; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_mc_control_fsm;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;
  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;

  typedef struct packed {
    logic [3:0]       state;
    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       pc_source;
    logic [2:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             illegal_op;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] pc_source;
  logic [2:0] alu_src_b;
  logic [3:0] alu_op;
  logic [3:0] state;
  logic illegal_op;
  logic [CNT_W-1:0] instr_count;

  mc_control_fsm #(.ALUOP_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .pc_source(pc_source),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cnt_m  = 0;

  // Monitor: every cycle the DUT presents a control word; compare to queue head
  always @(negedge clk) begin
    exp_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.state = state; a.pc_en = pc_en; a.iord = iord; a.mem_read = mem_read;
      a.mem_write = mem_write; a.ir_write = ir_write; a.mem_to_reg = mem_to_reg;
      a.reg_write = reg_write; a.reg_dst = reg_dst; a.alu_src_a = alu_src_a;
      a.pc_source = pc_source; a.alu_src_b = alu_src_b; a.alu_op = alu_op;
      a.illegal_op = illegal_op; a.cnt = instr_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_word check=%0d state got=%0d exp=%0d word got=%h exp=%h",
                 checks, a.state, e.state, a, e);
      end
      if (rst === 1'b1) begin
        checks++;
        if (state !== 4'd0 || instr_count !== '0 || pc_en !== 1'b0 ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || ir_write !== 1'b0 ||
            reg_write !== 1'b0 || illegal_op !== 1'b0) begin
          errors++;
          $display("FAIL reset_state check=%0d state=%0d cnt=%0d pc_en=%b mem_read=%b illegal_op=%b",
                   checks, state, instr_count, pc_en, mem_read, illegal_op);
        end
      end
      if ((e.state == 4'd7 || e.state == 4'd6) && rst === 1'b0 && mem_ready === 1'b1) begin
        checks++;
        if (state !== e.state || iord !== 1'b1 ||
            (e.state == 4'd7 && mem_read !== 1'b1) ||
            (e.state == 4'd6 && mem_write !== 1'b1)) begin
          errors++;
          $display("FAIL expired_wait check=%0d state got=%0d exp=%0d iord=%b mem_read=%b mem_write=%b",
                   checks, state, e.state, iord, mem_read, mem_write);
        end
      end
    end
  end

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic zv(input int zf);
    return (zf < 0) ? rb() : 1'(zf);
  endfunction

  function automatic exp_t mk(input int st);
    exp_t e;
    e = '0;
    e.state = 4'(st);
    e.cnt = CNT_W'(cnt_m);
    return e;
  endfunction

  function automatic int alu_of(input logic [5:0] f);
    case (f)
      6'h20: return int'(A_ADD);
      6'h22: return int'(A_SUB);
      6'h24: return int'(A_AND);
      6'h25: return int'(A_OR);
      6'h2A: return int'(A_SLT);
      default: return -1;
    endcase
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic cyc(input exp_t e, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic r);
    @(posedge clk);
    #1;
    rst = r; op = o; funct = f; zero = z; mem_ready = mr;
    exp_q.push_back(e);
  endtask

  task automatic reset_cyc();
    exp_t e;
    e = '0;
    cyc(e, rop(), rop(), rb(), rb(), 1'b1);
    cnt_m = 0;
  endtask

  task automatic trap(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = mk(13);
      e.illegal_op = 1'b1;
      cyc(e, rop(), rop(), rb(), rb(), 1'b0);
    end
    reset_cyc();
  endtask

  task automatic fetch_decode(input logic [5:0] opc, input logic [5:0] fn, input int fw, input int zf);
    exp_t e;
    for (int i = 0; i < fw; i++) begin
      e = mk(0); e.mem_read = 1'b1; e.alu_src_b = 3'd1; e.alu_op = A_ADD;
      cyc(e, rop(), fn, zv(zf), 1'b0, 1'b0);
    end
    e = mk(0); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_en = 1'b1;
    e.alu_src_b = 3'd1; e.alu_op = A_ADD;
    cyc(e, rop(), fn, zv(zf), 1'b1, 1'b0);
    cnt_m = (cnt_m + 1) % CMOD;
    e = mk(1); e.alu_src_b = 3'd3; e.alu_op = A_ADD;
    cyc(e, opc, fn, zv(zf), rb(), 1'b0);
  endtask

  // One full instruction: fw fetch waits, mw memory waits, zf fixed zero (-1 random), tl trap length
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fw,
                           input int mw, input int zf, input int tl);
    exp_t e;
    logic z;
    int a;
    int st;
    fetch_decode(opc, fn, fw, zf);
    case (opc)
      6'h00: begin
        a = alu_of(fn);
        e = mk(2); e.alu_src_a = 1'b1;
        if (a >= 0) e.alu_op = a[3:0];
        cyc(e, rop(), fn, zv(zf), rb(), 1'b0);
        if (a < 0) trap(tl);
        else begin
          e = mk(3); e.reg_dst = 1'b1; e.reg_write = 1'b1;
          cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
        end
      end
      6'h23, 6'h2B: begin
        e = mk(5); e.alu_src_a = 1'b1; e.alu_src_b = 3'd2; e.alu_op = A_ADD;
        cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
        st = (opc == 6'h23) ? 7 : 6;
        for (int i = 0; i <= mw; i++) begin
          e = mk(st); e.iord = 1'b1;
          if (st == 7) e.mem_read = 1'b1; else e.mem_write = 1'b1;
          cyc(e, rop(), rop(), zv(zf), (i == mw), 1'b0);
        end
        if (st == 7) begin
          e = mk(8); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
        end
      end
      6'h04, 6'h05: begin
        z = zv(zf);
        e = mk((opc == 6'h04) ? 4 : 12);
        e.alu_src_a = 1'b1; e.alu_op = A_SUB; e.pc_source = 2'd1;
        e.pc_en = (opc == 6'h04) ? z : !z;
        cyc(e, rop(), rop(), z, rb(), 1'b0);
      end
      6'h02: begin
        e = mk(9); e.pc_en = 1'b1; e.pc_source = 2'd2;
        cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
      end
      6'h08, 6'h0D: begin
        e = mk(10); e.alu_src_a = 1'b1;
        if (opc == 6'h0D) begin e.alu_src_b = 3'd4; e.alu_op = A_OR; end
        else begin e.alu_src_b = 3'd2; e.alu_op = A_ADD; end
        cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
        e = mk(11); e.reg_write = 1'b1;
        cyc(e, rop(), rop(), zv(zf), rb(), 1'b0);
      end
      default: trap(tl);
    endcase
  endtask

  // LW interrupted by reset while waiting in MEM_RD
  task automatic lw_abort();
    exp_t e;
    fetch_decode(6'h23, rop(), 0, -1);
    e = mk(5); e.alu_src_a = 1'b1; e.alu_src_b = 3'd2; e.alu_op = A_ADD;
    cyc(e, rop(), rop(), rb(), rb(), 1'b0);
    e = mk(7); e.iord = 1'b1; e.mem_read = 1'b1;
    cyc(e, rop(), rop(), rb(), 1'b0, 1'b0);
    reset_cyc();
  endtask

  logic [5:0] legal_ops [8];
  logic [5:0] legal_fn  [5];

  initial begin
    logic [5:0] o, f;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D};
    legal_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    reset_cyc();
    reset_cyc();

    run_instr(6'h23, 6'h11, 2, 3, -1, 1);          // LW with waits
    lw_abort();
    run_instr(6'h02, 6'h00, 0, 0, -1, 1);          // fetch resumes after reset
    run_instr(6'h04, 6'h00, 0, 0, 1, 1);           // BEQ zero=1
    run_instr(6'h05, 6'h00, 0, 0, 1, 1);           // BNE zero=1
    run_instr(6'h04, 6'h00, 0, 0, 0, 1);           // BEQ zero=0
    run_instr(6'h05, 6'h00, 0, 0, 0, 1);           // BNE zero=0
    run_instr(6'h0D, 6'h00, 0, 0, -1, 1);          // ORI
    run_instr(6'h08, 6'h00, 0, 0, -1, 1);          // ADDI
    run_instr(6'h2B, 6'h00, 1, 2, -1, 1);          // SW with waits
    for (int i = 0; i < 5; i++) run_instr(6'h00, legal_fn[i], 0, 0, -1, 1);
    run_instr(6'h3F, 6'h00, 0, 0, -1, 20);         // illegal opcode, sticky trap
    run_instr(6'h00, 6'h00, 0, 0, -1, 3);          // illegal funct
    for (int i = 0; i < 17; i++) run_instr(6'h02, 6'h00, 0, 0, -1, 1);  // counter wraps

    for (int n = 0; n < 200; n++) begin
      o = legal_ops[$urandom_range(0, 7)];
      f = legal_fn[$urandom_range(0, 4)];
      if ($urandom_range(0, 19) == 0) o = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h01;
      if (o == 6'h00 && $urandom_range(0, 19) == 0) f = 6'h00;
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2), -1, $urandom_range(1, 3));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS32 main control unit: owns the state register, decodes the opcode in DECODE, and drives every datapath control strobe per state. It sits between the instruction register and the datapath muxes, register file and memory port. It extends the original per-state decoder in four ways: ADDI/ORI/BNE support, a memory-ready wait handshake, a folded PC-enable, and an illegal-opcode trap plus a retired-instruction counter.

## Interface
- ALUOP_W, 4: width of alu_op; encodings are the `_ALUOP_*` macros in MyDefines.v.
- CNT_W, 32: width of instr_count.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0]; used only in R_EXEC.
- zero  in  1  ALU zero flag; sampled in BEQ/BNE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load enable (PCWrite, or PCWriteCond qualified by zero).
- iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  out  1 each  datapath strobes/selects.
- pc_source  out  2  0=ALU result, 1=ALUOut (branch), 2=jump target.
- alu_src_b  out  3  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2, 4=zero-ext imm.
- alu_op  out  ALUOP_W  ALU operation.
- state  out  4  current state code (debug).
- illegal_op  out  1  high while in TRAP.
- instr_count  out  CNT_W  instructions fetched since reset.

## Operation
- States and codes: FETCH 0, DECODE 1, R_EXEC 2, R_WB 3, BEQ 4, MEM_ADDR 5, MEM_WR 6, MEM_RD 7, LW_WB 8, JUMP 9, I_EXEC 10, I_WB 11, BNE 12, TRAP 13. Codes 14 and 15 are unreachable and go to TRAP.
- Every output defaults to 0 in every state; only the assertions listed below apply. No latches.
- FETCH: mem_read=1, ir_write=mem_ready, alu_src_b=1, alu_op=ADD, pc_en=mem_ready, pc_source=0. Stay in FETCH while mem_ready=0; on mem_ready=1, go to DECODE.
- DECODE: alu_src_b=3, alu_op=ADD. Next state by op: 0x00→R_EXEC; 0x23/0x2B→MEM_ADDR; 0x04→BEQ; 0x05→BNE; 0x02→JUMP; 0x08/0x0D→I_EXEC; any other opcode→TRAP.
- R_EXEC: alu_src_a=1, alu_src_b=0. alu_op decoded from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. An unknown funct goes to TRAP; otherwise go to R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0. Then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Go to MEM_RD if op=0x23, else MEM_WR. The op captured in DECODE is held internally, so a changing op input cannot misroute this transition.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then LW_WB.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- LW_WB: reg_dst=0, reg_write=1, mem_to_reg=1. Then FETCH.
- BEQ / BNE: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_source=1. pc_en=zero for BEQ and pc_en=~zero for BNE. Then FETCH.
- JUMP: pc_en=1, pc_source=2. Then FETCH.
- I_EXEC: alu_src_a=1. ADDI (0x08) uses alu_src_b=2 with alu_op=ADD; ORI (0x0D) uses alu_src_b=4 with alu_op=OR. Then I_WB.
- I_WB: reg_dst=0, reg_write=1, mem_to_reg=0. Then FETCH.
- TRAP: illegal_op=1, all strobes 0. TRAP is sticky; only rst leaves it.
- instr_count increments by 1 on each FETCH cycle with mem_ready=1. It wraps modulo 2^CNT_W with no flag.

## Timing
- Reset:
  - rst sampled high → state=FETCH, instr_count=0, and the latched op is cleared on the next edge.
  - While rst is high, all outputs are forced to 0, including pc_en, mem_read and illegal_op.
  - rst wins over any transition, including mid-access waits and TRAP.
- Outputs are combinational from state, latched op, funct, zero and mem_ready. Only state, latched op and instr_count are registered.
- Latency with mem_ready tied high:
  - R-type, ADDI, ORI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle and holds mem_read/mem_write and iord stable throughout.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

## Test plan
- Reset mid-MEM_RD with mem_ready=0: assert rst for 1 cycle → state=0, instr_count=0, all outputs 0 during rst, mem_read=1 again in FETCH after release.
- LW (op=0x23) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD → states 0,0,0,1,5,7,7,7,7,8,0; ir_write and pc_en pulse exactly once; instr_count=1.
- BEQ then BNE, each with zero=1 → BEQ: pc_en=1, pc_source=1 in state 4. BNE: pc_en=0 in state 12. Repeat with zero=0 → results inverted.
- ORI (0x0D) then ADDI (0x08) → state 10 shows alu_src_b=4, alu_op=`_ALUOP_OR`, then alu_src_b=2, alu_op=`_ALUOP_ADD`; reg_write=1 only in state 11.
- op=0x3F → TRAP after DECODE; illegal_op=1 held 20 cycles with all strobes 0; R-type funct=0x00 → also TRAP.
- CNT_W=4 with 17 back-to-back J instructions → instr_count wraps to 1; pc_en=1 with pc_source=2 in every JUMP state.
